// File: rtl/opb_stage_if.sv
// Operand-B stage bus: upstream operand/select fields, the valid/ready pair on
// each side, and the flush strobe. The stage uses the slave view.
interface opb_stage_if #(
    parameter int DW   = 16,
    parameter int IMMW = 3
);
    logic [1:0]      sel_in;
    logic [DW-1:0]   reg_in;
    logic [IMMW-1:0] imm_in;
    logic            valid_in;
    logic            ready_out;
    logic            flush_in;
    logic [DW-1:0]   m_out;
    logic            valid_out;
    logic            ready_in;

    modport slave (
        input  sel_in, reg_in, imm_in, valid_in, flush_in, ready_in,
        output ready_out, m_out, valid_out
    );

    modport master (
        output sel_in, reg_in, imm_in, valid_in, flush_in, ready_in,
        input  ready_out, m_out, valid_out
    );
endinterface

// File: rtl/opb_stage.sv
// Registered operand-B source selector for the ALU B input. Picks register,
// zero/sign-extended immediate or a constant, then holds it in a 2-entry skid
// buffer so the execute stage can stall without losing operands or throughput.
module opb_stage #(
    parameter int            DW    = 16,
    parameter int            IMMW  = 3,
    parameter logic [DW-1:0] CONST = DW'(16'h0001)
) (
    input logic         clk,
    input logic         rst_n,
    opb_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   main_q, main_d;
    logic [DW-1:0]   skid_q, skid_d;
    logic [DW-1:0]   src;
    logic            in_xfer;
    logic            out_xfer;

    function automatic logic [DW-1:0] zero_ext(input logic [IMMW-1:0] v);
        return DW'(v);
    endfunction

    // Casting a signed value to a wider size replicates its top bit.
    function automatic logic [DW-1:0] sign_ext(input logic [IMMW-1:0] v);
        logic signed [IMMW-1:0] s;
        s = signed'(v);
        return DW'(s);
    endfunction

    assign bus.ready_out = (state_q != FULL) && !bus.flush_in;
    assign bus.valid_out = (state_q != EMPTY);
    assign bus.m_out     = main_q;

    assign in_xfer  = bus.valid_in && bus.ready_out;
    assign out_xfer = bus.valid_out && bus.ready_in;

    // Operand source mux ahead of the storage registers.
    always_comb begin
        src = bus.reg_in;
        case (bus.sel_in)
            2'd0:    src = bus.reg_in;
            2'd1:    src = zero_ext(bus.imm_in);
            2'd2:    src = sign_ext(bus.imm_in);
            default: src = CONST;
        endcase
    end

    // Skid-buffer next state: main feeds m_out, skid catches the in-flight operand.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush_in) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = src;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = src;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = src;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and data registers; reset clears both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_opb_stage.sv
// Directed bench for opb_stage: reset, source mux/extension, backpressure,
// full throughput, flush and asynchronous reset while full.
module tb_opb_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    opb_stage_if #(.DW(16), .IMMW(3)) bus ();

    opb_stage #(.DW(16), .IMMW(3), .CONST(16'h0001)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel,
                         input logic [15:0] r, input logic [2:0] imm);
        bus.valid_in = v;
        bus.sel_in   = sel;
        bus.reg_in   = r;
        bus.imm_in   = imm;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.flush_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sel_in   = 2'($urandom);
            bus.reg_in   = 16'($urandom);
            bus.imm_in   = 3'($urandom);
            bus.valid_in = 1'($urandom);
            bus.ready_in = 1'($urandom);
            step();
        end
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
        checks++;
        if (bus.m_out !== 16'h0000) begin errors++; $display("FAIL reset_mout got=%h exp=0000", bus.m_out); end
        checks++;
        if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready_out); end
        drive(1'b0, 2'd0, 16'h0000, 3'd0);
        bus.ready_in = 1'b1;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.m_out !== 16'h0000 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got v=%b m=%h r=%b exp v=0 m=0000 r=1",
                     bus.valid_out, bus.m_out, bus.ready_out);
        end
    endtask

    task automatic test_mux();
        logic [1:0]  sel [4];
        logic [2:0]  imm [4];
        logic [15:0] rv  [4];
        logic [15:0] exp [4];
        sel = '{2'd1, 2'd2, 2'd0, 2'd3};
        imm = '{3'b101, 3'b101, 3'b000, 3'b000};
        rv  = '{16'h1234, 16'h1234, 16'hA5A5, 16'h5678};
        exp = '{16'h0005, 16'hFFFD, 16'hA5A5, 16'h0001};
        bus.ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sel[i], rv[i], imm[i]);
            step();
            checks++;
            if (bus.valid_out !== 1'b1 || bus.m_out !== exp[i]) begin
                errors++;
                $display("FAIL mux_%0d got v=%b m=%h exp v=1 m=%h", i, bus.valid_out, bus.m_out, exp[i]);
            end
        end
        drive(1'b0, 2'd0, 16'h0000, 3'd0);
        step();
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL mux_drain got=%b exp=0", bus.valid_out); end
    endtask

    task automatic test_backpressure();
        bus.ready_in = 1'b0;
        drive(1'b1, 2'd0, 16'h0011, 3'd0);
        step();
        checks++;
        if (bus.m_out !== 16'h0011 || bus.valid_out !== 1'b1 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got m=%h v=%b r=%b exp m=0011 v=1 r=1", bus.m_out, bus.valid_out, bus.ready_out);
        end
        drive(1'b1, 2'd0, 16'h0022, 3'd0);
        step();
        checks++;
        if (bus.m_out !== 16'h0011 || bus.ready_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got m=%h r=%b exp m=0011 r=0", bus.m_out, bus.ready_out);
        end
        drive(1'b1, 2'd0, 16'h0033, 3'd0);
        step();
        checks++;
        if (bus.m_out !== 16'h0011 || bus.ready_out !== 1'b0 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got m=%h r=%b v=%b exp m=0011 r=0 v=1", bus.m_out, bus.ready_out, bus.valid_out);
        end
        bus.ready_in = 1'b1;
        step();
        checks++;
        if (bus.m_out !== 16'h0022 || bus.valid_out !== 1'b1 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got m=%h v=%b r=%b exp m=0022 v=1 r=1", bus.m_out, bus.valid_out, bus.ready_out);
        end
        step();
        checks++;
        if (bus.m_out !== 16'h0033 || bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_third got m=%h v=%b exp m=0033 v=1", bus.m_out, bus.valid_out);
        end
        drive(1'b0, 2'd0, 16'h0000, 3'd0);
        step();
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", bus.valid_out); end
    endtask

    task automatic test_back_to_back();
        bus.ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd0, 16'(i), 3'd0);
            step();
            checks++;
            if (bus.valid_out !== 1'b1 || bus.m_out !== 16'(i)) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b m=%h exp v=1 m=%h", i, bus.valid_out, bus.m_out, 16'(i));
            end
        end
        drive(1'b0, 2'd0, 16'h0000, 3'd0);
        step();
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", bus.valid_out); end
    endtask

    task automatic test_flush();
        bus.ready_in = 1'b0;
        drive(1'b1, 2'd0, 16'h0101, 3'd0);
        step();
        drive(1'b1, 2'd0, 16'h0202, 3'd0);
        step();
        drive(1'b1, 2'd0, 16'hBEEF, 3'd0);
        bus.flush_in = 1'b1;
        #1;
        checks++;
        if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL flush_ready_low got=%b exp=0", bus.ready_out); end
        step();
        bus.flush_in = 1'b0;
        drive(1'b0, 2'd0, 16'h0000, 3'd0);
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty got v=%b r=%b exp v=0 r=1", bus.valid_out, bus.ready_out);
        end
        bus.ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.valid_out !== 1'b0 || bus.m_out === 16'hBEEF) begin
                errors++;
                $display("FAIL flush_after_%0d got v=%b m=%h exp v=0 m!=beef", i, bus.valid_out, bus.m_out);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.ready_in = 1'b0;
        drive(1'b1, 2'd0, 16'h0A0A, 3'd0);
        step();
        drive(1'b1, 2'd0, 16'h0B0B, 3'd0);
        step();
        drive(1'b0, 2'd0, 16'h0000, 3'd0);
        checks++;
        if (bus.ready_out !== 1'b0 || bus.m_out !== 16'h0A0A) begin
            errors++;
            $display("FAIL areset_pre got r=%b m=%h exp r=0 m=0a0a", bus.ready_out, bus.m_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.m_out !== 16'h0000 || bus.ready_out !== 1'b1) begin
            errors++;
            $display("FAIL areset_now got v=%b m=%h r=%b exp v=0 m=0000 r=1",
                     bus.valid_out, bus.m_out, bus.ready_out);
        end
        step();
        rst_n = 1'b1;
        bus.ready_in = 1'b1;
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.m_out !== 16'h0000) begin
            errors++;
            $display("FAIL areset_after got v=%b m=%h exp v=0 m=0000", bus.valid_out, bus.m_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.flush_in = 1'b0;
        bus.ready_in = 1'b0;
        drive(1'b0, 2'd0, 16'h0000, 3'd0);
        test_reset();
        test_mux();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
